// File: rtl/spi_mem_pkg.sv
// Shared types and constants for the SPI memory controller: FSM states,
// default opcodes and the frame layout (opcode + address + data word).
package spi_mem_pkg;

  localparam int CMD_BITS   = 8;
  localparam int ADDR_BITS  = 24;
  localparam int DATA_BITS  = 16;
  localparam int FRAME_BITS = CMD_BITS + ADDR_BITS + DATA_BITS;
  localparam int CNT_W      = $clog2(FRAME_BITS + 1);

  localparam logic [CMD_BITS-1:0] OP_READ  = 8'h03;
  localparam logic [CMD_BITS-1:0] OP_WRITE = 8'h02;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DATA,
    ST_FINISH
  } state_t;

  // Assemble the outgoing frame, MSB first on the wire.
  function automatic logic [FRAME_BITS-1:0] build_frame(
    input logic [CMD_BITS-1:0]  op,
    input logic [ADDR_BITS-1:0] addr,
    input logic [DATA_BITS-1:0] data
  );
    return {op, addr, data};
  endfunction

endpackage

// File: rtl/spi_mem_shifter.sv
// Serial datapath: parallel-load shift-out register for the outgoing frame,
// shift-in register for the read word, and the count of completed bits.
module spi_mem_shifter
  import spi_mem_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_i,
  input  logic [FRAME_BITS-1:0] frame_i,
  input  logic                  shift_i,
  input  logic                  sample_i,
  input  logic                  miso_i,
  output logic                  mosi_o,
  output logic [DATA_BITS-1:0]  rx_o,
  output logic [CNT_W-1:0]      cnt_o
);

  logic [FRAME_BITS-1:0] tx_q, tx_d;
  logic [DATA_BITS-1:0]  rx_q, rx_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  // Next-state for the shift registers and bit counter.
  always_comb begin
    tx_d  = tx_q;
    rx_d  = rx_q;
    cnt_d = cnt_q;
    if (load_i) begin
      tx_d  = frame_i;
      cnt_d = '0;
    end else if (shift_i) begin
      tx_d  = {tx_q[FRAME_BITS-2:0], 1'b0};
      cnt_d = cnt_q + CNT_W'(1);
    end
    if (sample_i) begin
      rx_d = {rx_q[DATA_BITS-2:0], miso_i};
    end
  end

  // Register update with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: the shift registers are reset too, so mosi and rdata are defined
    // zero after reset rather than leftover frame bits.
    if (rst) begin
      tx_q  <= '0;
      rx_q  <= '0;
      cnt_q <= '0;
    end else begin
      tx_q  <= tx_d;
      rx_q  <= rx_d;
      cnt_q <= cnt_d;
    end
  end

  assign mosi_o = tx_q[FRAME_BITS-1];
  assign rx_o   = rx_q;
  assign cnt_o  = cnt_q;

endmodule

// File: rtl/spi_mem_ctrl.sv
// SPI memory controller: issues one 48-bit mode-0 frame (opcode, 24-bit
// address, 16-bit word) per accepted start; each bit is a low phase followed
// by a high phase of one clk cycle each.
module spi_mem_ctrl
  import spi_mem_pkg::*;
#(
  parameter logic [7:0] CMD_READ  = OP_READ,
  parameter logic [7:0] CMD_WRITE = OP_WRITE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 write,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [DATA_BITS-1:0] wdata,
  output logic [DATA_BITS-1:0] rdata,
  output logic                 busy,
  output logic                 done,
  output logic                 spi_select,
  output logic                 spi_clk,
  output logic                 spi_mosi,
  input  logic                 spi_miso
);

  state_t state_q, state_d;
  logic   phase_q, phase_d;   // 0 = low phase, 1 = high phase of a bit
  logic   write_q, write_d;

  logic                  in_frame;
  logic                  accept;
  logic                  bit_end;
  logic                  load;
  logic                  shift;
  logic                  sample;
  logic                  tx_bit;
  logic [FRAME_BITS-1:0] frame;
  logic [CNT_W-1:0]      bit_cnt;

  assign in_frame = (state_q inside {ST_CMD, ST_ADDR, ST_DATA});
  // A new request is taken when idle or in the completion cycle.
  assign accept   = start && (state_q inside {ST_IDLE, ST_FINISH});
  assign bit_end  = in_frame && phase_q;

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q <= ST_IDLE;
      phase_q <= 1'b0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      write_q <= write_d;
    end
  end

  // Next-state: advance on the last bit of each field.
  always_comb begin
    // NOTE: defaults first so no path leaves a signal unassigned (no latches).
    state_d = state_q;
    phase_d = 1'b0;
    write_d = write_q;
    if (in_frame) begin
      phase_d = ~phase_q;
    end
    if (accept) begin
      write_d = write;
    end
    unique case (state_q)
      ST_IDLE:   if (start) state_d = ST_CMD;
      ST_CMD:    if (bit_end && bit_cnt == CNT_W'(CMD_BITS - 1)) state_d = ST_ADDR;
      ST_ADDR:   if (bit_end && bit_cnt == CNT_W'(CMD_BITS + ADDR_BITS - 1)) state_d = ST_DATA;
      ST_DATA:   if (bit_end && bit_cnt == CNT_W'(FRAME_BITS - 1)) state_d = ST_FINISH;
      ST_FINISH: state_d = start ? ST_CMD : ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Outputs and datapath controls decoded from state and bit phase.
  always_comb begin
    busy       = in_frame;
    done       = (state_q == ST_FINISH);
    spi_select = ~in_frame;
    spi_clk    = in_frame & phase_q;
    spi_mosi   = in_frame & tx_bit;
    load       = accept;
    shift      = bit_end;
    sample     = bit_end && (state_q == ST_DATA) && !write_q;
    frame      = build_frame(write ? CMD_WRITE : CMD_READ, addr,
                             write ? wdata : '0);
  end

  spi_mem_shifter u_shifter (
    .clk      (clk),
    .rst      (rst),
    .load_i   (load),
    .frame_i  (frame),
    .shift_i  (shift),
    .sample_i (sample),
    .miso_i   (spi_miso),
    .mosi_o   (tx_bit),
    .rx_o     (rdata),
    .cnt_o    (bit_cnt)
  );

endmodule

// File: tb/tb_spi_mem_ctrl.sv
// Bench for spi_mem_ctrl: behavioural SPI RAM on the serial pins, a
// byte-array reference memory, and a scoreboard checked at each done pulse.
module tb_spi_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        write;
  logic [23:0] addr;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        busy;
  logic        done;
  logic        spi_select;
  logic        spi_clk;
  logic        spi_mosi;
  logic        spi_miso = 1'b0;

  spi_mem_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .write      (write),
    .addr       (addr),
    .wdata      (wdata),
    .rdata      (rdata),
    .busy       (busy),
    .done       (done),
    .spi_select (spi_select),
    .spi_clk    (spi_clk),
    .spi_mosi   (spi_mosi),
    .spi_miso   (spi_miso)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        wr;
    logic [23:0] a;
    logic [15:0] rd;
    logic [47:0] frame;
    int          t0;
  } exp_t;

  exp_t        exp_q[$];
  logic [47:0] got_frames[$];
  logic [7:0]  slave_mem[int];
  logic [7:0]  ref_mem[int];
  logic [15:0] last_rd = 16'h0000;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] sb(input int a);
    return slave_mem.exists(a) ? slave_mem[a] : 8'h00;
  endfunction

  function automatic logic [7:0] rb(input int a);
    return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
  endfunction

  // ---------------- SPI RAM model (mode 0) ----------------
  int          s_cnt = 0;
  logic [47:0] s_sh  = '0;
  logic [7:0]  s_op  = '0;
  logic [15:0] s_word = '0;

  always @(negedge spi_select) begin
    s_cnt = 0;
    s_sh  = '0;
  end

  always @(posedge spi_clk) begin
    s_sh = {s_sh[46:0], spi_mosi};
    s_cnt++;
    if (s_cnt == 8) s_op = s_sh[7:0];
    if (s_cnt == 32 && s_op == 8'h03)
      s_word = {sb(int'(s_sh[23:0])), sb(int'(s_sh[23:0]) + 1)};
    if (s_cnt == 48) begin
      got_frames.push_back(s_sh);
      if (s_op == 8'h02) begin
        slave_mem[int'(s_sh[39:16])]     = s_sh[15:8];
        slave_mem[int'(s_sh[39:16]) + 1] = s_sh[7:0];
      end
    end
  end

  always @(negedge spi_clk) begin
    if (s_cnt >= 32 && s_cnt < 48 && s_op == 8'h03) spi_miso = s_word[47 - s_cnt];
  end

  // ---------------- monitor / scoreboard ----------------
  int   busy_run  = 0;
  logic prev_clk  = 1'b0;
  logic prev_mosi = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    check("clk_idle_when_deselected", spi_clk & spi_select, 1'b0);
    if (spi_clk) begin
      check("mosi_hold", spi_mosi, prev_mosi);
      check("clk_phase", prev_clk, 1'b0);
    end
    if (done) begin
      if (exp_q.size() == 0) begin
        check("spurious_done", done, 1'b0);
      end else begin
        e = exp_q.pop_front();
        check("done_cycle", cyc + 1, e.t0 + 97);
        check("busy_len", busy_run, 96);
        check("done_select", spi_select, 1'b1);
        check("done_busy", busy, 1'b0);
        check("frame_count", got_frames.size(), 1);
        if (got_frames.size() != 0) check("mosi_frame", got_frames.pop_front(), e.frame);
        check(e.wr ? "rdata_kept_on_write" : "rdata", rdata, e.rd);
      end
    end
    busy_run  = busy ? busy_run + 1 : 0;
    prev_clk  = spi_clk;
    prev_mosi = spi_mosi;
  end

  // ---------------- stimulus ----------------
  task automatic push_exp(input logic wr, input logic [23:0] a, input logic [15:0] d);
    exp_t e;
    e.wr    = wr;
    e.a     = a;
    e.t0    = cyc + 1;
    e.frame = {(wr ? 8'h02 : 8'h03), a, (wr ? d : 16'h0000)};
    if (wr) begin
      ref_mem[int'(a)]     = d[15:8];
      ref_mem[int'(a) + 1] = d[7:0];
    end else begin
      last_rd = {rb(int'(a)), rb(int'(a) + 1)};
    end
    e.rd = last_rd;
    exp_q.push_back(e);
  endtask

  int last_t0 = 0;

  task automatic issue(input logic wr, input logic [23:0] a, input logic [15:0] d);
    int n = 0;
    @(negedge clk);
    while (busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (busy) check("issue_wait", busy, 1'b0);
    start = 1'b1;
    write = wr;
    addr  = a;
    wdata = d;
    push_exp(wr, a, d);
    last_t0 = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    write = 1'($urandom);
    addr  = 24'($urandom);
    wdata = 16'($urandom);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("drain", exp_q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    logic [15:0] w2;
    int t_a;
    rst = 1'b1; start = 1'b1; write = 1'b0; addr = '0; wdata = '0;
    w2 = 16'($urandom);
    slave_mem[0] = 8'h12; slave_mem[1] = 8'h34;
    slave_mem[2] = w2[15:8]; slave_mem[3] = w2[7:0];
    ref_mem = slave_mem;

    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_select", spi_select, 1'b1);
    check("rst_spi_clk", spi_clk, 1'b0);
    check("rst_mosi", spi_mosi, 1'b0);
    check("rst_rdata", rdata, 16'h0000);

    // start held through reset: first acceptance on first edge with rst low
    rst = 1'b0;
    push_exp(1'b0, 24'h000000, 16'h0000);
    @(negedge clk);
    start = 1'b0;
    check("first_accept_busy", busy, 1'b1);
    wait_idle();

    // write 0xBEEF to 0x10, then read it back
    issue(1'b1, 24'h000010, 16'hBEEF);
    wait_idle();
    check("model_word_0x10", {sb(16), sb(17)}, 16'hBEEF);
    issue(1'b0, 24'h000010, 16'h0000);
    wait_idle();

    // back-to-back reads of 0x0 and 0x2
    issue(1'b0, 24'h000000, 16'h0000);
    t_a = last_t0;
    issue(1'b0, 24'h000002, 16'h0000);
    check("b2b_gap", last_t0 - t_a, 97);
    check("b2b_select_low", spi_select, 1'b0);
    wait_idle();

    // start pulse mid-frame must be ignored, inputs changed underneath
    issue(1'b1, 24'h000020, 16'hA5A5);
    repeat (38) @(negedge clk);
    start = 1'b1; write = 1'b1; addr = 24'h000030; wdata = 16'h5A5A;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    check("ignored_write", {sb(48), sb(49)}, 16'h0000);

    // reset mid-read aborts without done
    issue(1'b0, 24'h000010, 16'h0000);
    repeat (48) @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    last_rd = 16'h0000;
    @(negedge clk);
    check("abort_select", spi_select, 1'b1);
    check("abort_busy", busy, 1'b0);
    check("abort_rdata", rdata, 16'h0000);
    check("abort_done", done, 1'b0);
    check("abort_spi_clk", spi_clk, 1'b0);
    rst = 1'b0;
    issue(1'b0, 24'h000010, 16'h0000);
    wait_idle();

    // randomized traffic over a small address window
    for (int i = 0; i < 24; i++) begin
      issue(1'($urandom), 24'($urandom_range(0, 63)), 16'($urandom));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_idle();
    check("frames_consumed", got_frames.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
